// File: rtl/data_bus_bridge_if.sv
// rtl/data_bus_bridge_if.sv - Bus-side request/response signals of the core-to-bus bridge.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

interface data_bus_bridge_if #(
    parameter int WIDTH = `BIT_COUNT
);
    logic               BusReq;
    logic               BusWe;
    logic [WIDTH/8-1:0] BusByteEn;
    logic [WIDTH-1:0]   BusAdr;
    logic [WIDTH-1:0]   BusWData;
    logic               BusAck;
    logic               BusErr;
    logic [WIDTH-1:0]   BusRData;

    modport master (
        output BusReq, BusWe, BusByteEn, BusAdr, BusWData,
        input  BusAck, BusErr, BusRData
    );

    modport slave (
        input  BusReq, BusWe, BusByteEn, BusAdr, BusWData,
        output BusAck, BusErr, BusRData
    );
endinterface

// File: rtl/data_bus_bridge.sv
// rtl/data_bus_bridge.sv - Single-outstanding core memory access to bus bridge with timeout and sticky fault.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module data_bus_bridge #(
    parameter int WIDTH   = `BIT_COUNT,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemEn,
    input  logic               MemWrite,
    input  logic [WIDTH/8-1:0] ByteEn,
    input  logic [WIDTH-1:0]   MemAdr,
    input  logic [WIDTH-1:0]   MemWriteData,
    output logic [WIDTH-1:0]   MemReadData,
    output logic               Stall,
    output logic               Fault,
    output logic [WIDTH-1:0]   FaultAdr,
    data_bus_bridge_if.master  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] ADR_MASK = ~(WIDTH'(WIDTH / 8 - 1));

    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

    state_t           state;
    logic [CW-1:0]    wait_cnt;
    logic [WIDTH-1:0] adr_q;

    // Full byte address is kept for fault reporting; the bus only sees it word-aligned.
    assign bus.BusAdr = adr_q & ADR_MASK;

    assign Stall = ((state == IDLE) && MemEn) || (state == REQ) || (state == FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            Fault         <= 1'b0;
            FaultAdr      <= '0;
            MemReadData   <= '0;
            adr_q         <= '0;
            bus.BusReq    <= 1'b0;
            bus.BusWe     <= 1'b0;
            bus.BusByteEn <= '0;
            bus.BusWData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemEn) begin
                        if (|ByteEn) begin
                            bus.BusWe     <= MemWrite;
                            bus.BusByteEn <= ByteEn;
                            bus.BusWData  <= MemWriteData;
                            adr_q         <= MemAdr;
                            wait_cnt      <= '0;
                            bus.BusReq    <= 1'b1;
                            state         <= REQ;
                        end else begin
                            Fault    <= 1'b1;
                            FaultAdr <= MemAdr;
                            state    <= FAULT;
                        end
                    end
                end
                REQ: begin
                    if (bus.BusAck) begin
                        bus.BusReq <= 1'b0;
                        if (bus.BusErr) begin
                            Fault    <= 1'b1;
                            FaultAdr <= adr_q;
                            state    <= FAULT;
                        end else begin
                            if (!bus.BusWe)
                                MemReadData <= bus.BusRData;
                            state <= DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // Counter reaches TIMEOUT on this edge, so give up now.
                        if (wait_cnt == CW'(TIMEOUT - 1)) begin
                            bus.BusReq <= 1'b0;
                            Fault      <= 1'b1;
                            FaultAdr   <= adr_q;
                            state      <= FAULT;
                        end
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
